// File: rtl/seq2_prog_ctrl.sv
// rtl/seq2_prog_ctrl.sv - program RAM and two-cycle fetch controller for the Seq2 microsequencer
module seq2_prog_ctrl #(
  parameter int AddrWidth = 8,
  parameter int InstWidth = 20,
  parameter int MaxOpcode = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_valid,
  input  logic [AddrWidth-1:0] load_addr,
  input  logic [InstWidth-1:0] load_data,
  output logic                 load_ready,
  input  logic                 start,
  input  logic                 stop,
  input  logic [AddrWidth-1:0] seq_next,
  output logic [InstWidth-1:0] seq_inst,
  output logic                 seq_inst_en,
  output logic                 seq_reset,
  output logic                 busy,
  output logic                 error,
  output logic [15:0]          fetch_count
);

  localparam logic [3:0] MaxOp = 4'(MaxOpcode);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    FETCH,
    EXEC,
    HALT
  } state_t;

  state_t               state_q;
  logic [InstWidth-1:0] mem_q [2**AddrWidth];
  logic [InstWidth-1:0] inst_q;
  logic                 seq_reset_q;
  logic                 busy_q;
  logic                 error_q;
  logic                 ready_q;
  logic [15:0]          count_q;
  logic [15:0]          count_d;
  logic                 legal;

  assign legal       = inst_q[InstWidth-1 -: 4] <= MaxOp;
  assign count_d     = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
  // stop masks the enable in the very cycle it is seen, so Seq2 never executes past an abort
  assign seq_inst_en = (state_q == EXEC) && legal && !stop;

  assign seq_inst    = inst_q;
  assign seq_reset   = seq_reset_q;
  assign busy        = busy_q;
  assign error       = error_q;
  assign load_ready  = ready_q;
  assign fetch_count = count_q;

  // RAM is deliberately not reset so a program survives an asynchronous reset
  always_ff @(posedge clock) begin
    if (ready_q && load_valid) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      inst_q      <= '0;
      seq_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      ready_q     <= 1'b1;
      count_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_q     <= SETTLE;
            seq_reset_q <= 1'b0;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            count_q     <= '0;
          end
        end
        SETTLE, FETCH, EXEC: begin
          if (stop) begin
            state_q     <= IDLE;
            seq_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
          end else if (state_q == SETTLE) begin
            state_q     <= FETCH;
            seq_reset_q <= 1'b0;
          end else if (state_q == FETCH) begin
            state_q <= EXEC;
            inst_q  <= mem_q[seq_next];
          end else if (legal) begin
            state_q <= FETCH;
            count_q <= count_d;
          end else begin
            state_q <= HALT;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end
        end
        HALT: begin
          if (stop) begin
            state_q     <= IDLE;
            seq_reset_q <= 1'b1;
            ready_q     <= 1'b1;
          end else if (start) begin
            // one SETTLE cycle with Seq2 held in reset, since HALT left it mid-program
            state_q     <= SETTLE;
            seq_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            error_q     <= 1'b0;
            count_q     <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          seq_reset_q <= 1'b1;
          busy_q      <= 1'b0;
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq2_prog_ctrl.sv
// tb/tb_seq2_prog_ctrl.sv - self-checking bench for seq2_prog_ctrl with a small Seq2 stand-in
module tb_seq2_prog_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_addr;
  logic [19:0] load_data;
  logic        load_ready;
  logic        start;
  logic        stop;
  logic [7:0]  seq_next;
  logic [19:0] seq_inst;
  logic        seq_inst_en;
  logic        seq_reset;
  logic        busy;
  logic        error;
  logic [15:0] fetch_count;

  int n_total = 0;
  int n_pass  = 0;

  logic [19:0] model_mem [256];
  logic [19:0] exp_q [$];

  always #5 clock = ~clock;

  seq2_prog_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .start       (start),
    .stop        (stop),
    .seq_next    (seq_next),
    .seq_inst    (seq_inst),
    .seq_inst_en (seq_inst_en),
    .seq_reset   (seq_reset),
    .busy        (busy),
    .error       (error),
    .fetch_count (fetch_count)
  );

  // Seq2 stand-in: JI (opcode 3) jumps to the low byte, anything else steps by one
  logic [7:0] pc;
  always @(posedge clock) begin
    if (seq_reset) pc <= 8'd0;
    else if (seq_inst_en) pc <= (seq_inst[19:16] == 4'd3) ? seq_inst[7:0] : pc + 8'd1;
  end
  assign seq_next = pc;

  typedef struct {
    logic        start;
    logic        stop;
    logic        exp_rst;
    logic        exp_en;
    logic        exp_busy;
    logic        exp_ready;
    logic [19:0] exp_inst;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic st, input logic sp, input logic r, input logic e,
                              input logic b, input logic rd, input logic [19:0] ins,
                              input logic [15:0] c);
    vec_t v;
    v.start = st; v.stop = sp; v.exp_rst = r; v.exp_en = e;
    v.exp_busy = b; v.exp_ready = rd; v.exp_inst = ins; v.exp_cnt = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [19:0] d);
    load_valid = 1'b1; load_addr = a; load_data = d;
    step();
    load_valid = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic wait_pulse(output logic [19:0] inst, output int steps);
    bit done;
    done = 1'b0;
    steps = 0;
    inst = '0;
    while (!done && steps < 8) begin
      step();
      steps++;
      if (seq_inst_en) begin
        inst = seq_inst;
        done = 1'b1;
      end
    end
    if (!done) steps = 99;
  endtask

  // Walk the program from address 0 the way Seq2 would, listing what should be enabled
  task automatic build_exp(input int maxn, output bit halts);
    logic [7:0]  a;
    logic [19:0] w;
    exp_q.delete();
    a = 8'd0;
    halts = 1'b0;
    for (int k = 0; k < maxn && !halts; k++) begin
      w = model_mem[a];
      if (int'(w[19:16]) > 6) halts = 1'b1;
      else begin
        exp_q.push_back(w);
        a = (w[19:16] == 4'd3) ? w[7:0] : a + 8'd1;
      end
    end
  endtask

  initial begin
    logic [19:0] got;
    int          steps;
    int          waited;
    bit          halts;

    reset = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; stop = 1'b0;
    #23;
    check("rst_seq_reset", 32'(seq_reset), 32'd1);
    check("rst_en", 32'(seq_inst_en), 32'd0);
    check("rst_inst", 32'(seq_inst), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_count", 32'(fetch_count), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    step();

    // basic CI / JI loop, then a stop landing in an EXEC cycle
    load(8'd0, 20'h101AB);
    load(8'd1, 20'h30000);
    tbl[0]  = mk(1, 0, 1, 0, 0, 1, 20'h0,     16'd0);
    tbl[1]  = mk(0, 0, 0, 0, 1, 0, 20'h0,     16'd0);
    tbl[2]  = mk(0, 0, 0, 0, 1, 0, 20'h0,     16'd0);
    tbl[3]  = mk(0, 0, 0, 1, 1, 0, 20'h101AB, 16'd0);
    tbl[4]  = mk(0, 0, 0, 0, 1, 0, 20'h101AB, 16'd1);
    tbl[5]  = mk(0, 0, 0, 1, 1, 0, 20'h30000, 16'd1);
    tbl[6]  = mk(0, 0, 0, 0, 1, 0, 20'h30000, 16'd2);
    tbl[7]  = mk(0, 0, 0, 1, 1, 0, 20'h101AB, 16'd2);
    tbl[8]  = mk(0, 0, 0, 0, 1, 0, 20'h101AB, 16'd3);
    tbl[9]  = mk(0, 0, 0, 1, 1, 0, 20'h30000, 16'd3);
    tbl[10] = mk(0, 0, 0, 0, 1, 0, 20'h30000, 16'd4);
    tbl[11] = mk(0, 1, 0, 0, 1, 0, 20'h101AB, 16'd4);
    tbl[12] = mk(0, 0, 1, 0, 0, 1, 20'h101AB, 16'd4);
    for (int i = 0; i < 13; i++) begin
      start = tbl[i].start;
      stop  = tbl[i].stop;
      #1;
      check($sformatf("v%0d_seq_reset", i), 32'(seq_reset), 32'(tbl[i].exp_rst));
      check($sformatf("v%0d_en", i), 32'(seq_inst_en), 32'(tbl[i].exp_en));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      check($sformatf("v%0d_ready", i), 32'(load_ready), 32'(tbl[i].exp_ready));
      check($sformatf("v%0d_inst", i), 32'(seq_inst), 32'(tbl[i].exp_inst));
      check($sformatf("v%0d_count", i), 32'(fetch_count), 32'(tbl[i].exp_cnt));
      step();
    end
    start = 1'b0; stop = 1'b0;

    // illegal opcode halts without ever enabling it
    load(8'd0, 20'h70000);
    do_start();
    step();
    step();
    check("ill_exec_en", 32'(seq_inst_en), 32'd0);
    step();
    check("ill_error", 32'(error), 32'd1);
    check("ill_busy", 32'(busy), 32'd0);
    check("ill_count", 32'(fetch_count), 32'd0);
    check("ill_halt_seq_reset", 32'(seq_reset), 32'd0);
    check("ill_halt_ready", 32'(load_ready), 32'd0);
    do_start();
    check("restart_error", 32'(error), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_seq_reset", 32'(seq_reset), 32'd1);
    step();
    check("restart_settle_done", 32'(seq_reset), 32'd0);
    step();
    step();
    do_stop();
    check("halt_stop_ready", 32'(load_ready), 32'd1);

    // writes while running are dropped
    load(8'd0, 20'h101AB);
    do_start();
    wait_pulse(got, steps);
    check("run1_inst", 32'(got), 32'h101AB);
    load_valid = 1'b1; load_addr = 8'd0; load_data = 20'hFFFFF;
    step();
    load_valid = 1'b0;
    check("run_ready_low", 32'(load_ready), 32'd0);
    do_stop();
    do_start();
    wait_pulse(got, steps);
    check("rerun_inst", 32'(got), 32'h101AB);
    do_stop();

    // start together with stop, then start together with a write
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(busy), 32'd0);
    check("startstop_ready", 32'(load_ready), 32'd1);
    load_valid = 1'b1; load_addr = 8'd0; load_data = 20'h102CD; start = 1'b1;
    step();
    load_valid = 1'b0; start = 1'b0;
    model_mem[0] = 20'h102CD;
    wait_pulse(got, steps);
    check("startload_inst", 32'(got), 32'h102CD);
    check("startload_latency", 32'(steps), 32'd2);

    // asynchronous reset while in EXEC
    reset = 1'b0;
    #1;
    check("arst_en", 32'(seq_inst_en), 32'd0);
    check("arst_seq_reset", 32'(seq_reset), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_count", 32'(fetch_count), 32'd0);
    check("arst_inst", 32'(seq_inst), 32'd0);
    check("arst_ready", 32'(load_ready), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    step();
    do_start();
    wait_pulse(got, steps);
    check("post_rst_inst0", 32'(got), 32'(model_mem[0]));
    wait_pulse(got, steps);
    check("post_rst_inst1", 32'(got), 32'(model_mem[1]));
    do_stop();

    // random programs against the walk model
    for (int t = 0; t < 5; t++) begin
      for (int a = 0; a < 16; a++) begin
        logic [3:0]  op;
        logic [19:0] w;
        int          r;
        r = int'($urandom_range(0, 11));
        op = (r < 10) ? 4'(r % 7) : 4'($urandom_range(7, 15));
        if (a == 15) op = 4'd3;
        w = {op, 8'($urandom), 8'($urandom_range(0, 14))};
        load(8'(a), w);
      end
      build_exp(12, halts);
      do_start();
      foreach (exp_q[k]) begin
        wait_pulse(got, steps);
        check($sformatf("rnd%0d_inst%0d", t, k), 32'(got), 32'(exp_q[k]));
        check($sformatf("rnd%0d_cadence%0d", t, k), 32'(steps), 32'd2);
      end
      if (halts) begin
        waited = 0;
        while (busy && waited < 8) begin
          step();
          waited++;
        end
        check($sformatf("rnd%0d_halt_busy", t), 32'(busy), 32'd0);
        check($sformatf("rnd%0d_halt_error", t), 32'(error), 32'd1);
        check($sformatf("rnd%0d_halt_count", t), 32'(fetch_count), 32'(exp_q.size()));
        do_stop();
      end else begin
        stop = 1'b1;
        #1;
        check($sformatf("rnd%0d_stop_en", t), 32'(seq_inst_en), 32'd0);
        step();
        stop = 1'b0;
        check($sformatf("rnd%0d_stop_ready", t), 32'(load_ready), 32'd1);
        check($sformatf("rnd%0d_stop_seq_reset", t), 32'(seq_reset), 32'd1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
